// File: rtl/pdl_ctl.sv
// pdl_ctl: PDL buffer address/strobe control with push/pop pointer, index and one-cycle deferred write; sticky wrap flag pdl_ovf only when PDL_BOUNDS_EN is defined
module pdl_ctl (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [9:0] ob,
  input  logic       srcpdlpop,
  input  logic       srcpdltop,
  input  logic       srcpdlx,
  input  logic       destpdltop,
  input  logic       destpdlp,
  input  logic       destpdlx,
  input  logic       destpdlptr,
  input  logic       destpdlidx,
  output logic [9:0] pdla,
  output logic       prp,
  output logic       pwp,
  output logic [9:0] pdlptr,
  output logic [9:0] pdlidx,
  output logic       pdl_stall,
  output logic       pdl_ovf
);
  typedef enum logic {IDLE, WPEND} phase_t;
  phase_t phase;
  logic rd, stall, adv, pop, d_idx, d_top, d_p, d_x, cap;
  logic [9:0] ptr_next, wadr;
  always_comb begin
    rd = step & (srcpdlpop | srcpdltop | srcpdlx);
    stall = (phase == WPEND) & rd;
    adv = step & ~stall;
    pop = srcpdlpop & ~srcpdlx;
    d_idx = destpdlidx & ~destpdlptr;
    d_top = destpdltop & ~destpdlptr & ~destpdlidx;
    d_p = destpdlp & ~destpdlptr & ~destpdlidx & ~destpdltop;
    d_x = destpdlx & ~destpdlptr & ~destpdlidx & ~destpdltop & ~destpdlp;
    cap = d_top | d_p | d_x;
    ptr_next = destpdlptr ? ob : pdlptr - {9'd0, pop} + {9'd0, d_top};
    pwp = ~reset & (phase == WPEND);
    prp = ~reset & rd & (phase == IDLE);
    pdl_stall = ~reset & stall;
    pdla = reset ? 10'd0 : (phase == WPEND) ? wadr : srcpdlx ? pdlidx : pdlptr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= IDLE;
      pdlptr <= 10'd0;
      pdlidx <= 10'd0;
      wadr <= 10'd0;
    end else if (adv) begin
      pdlptr <= ptr_next;
      if (d_idx) pdlidx <= ob;
      if (cap) wadr <= d_x ? pdlidx : ptr_next;
      phase <= cap ? WPEND : IDLE;
    end else begin
      phase <= IDLE;
    end
  end
`ifdef PDL_BOUNDS_EN
  always_ff @(posedge clk) begin
    if (reset) pdl_ovf <= 1'b0;
    else if (adv & destpdlptr) pdl_ovf <= 1'b0;
    else if (adv & ((d_top & ~pop & (&pdlptr)) | (pop & ~d_top & ~(|pdlptr)))) pdl_ovf <= 1'b1;
  end
`else
  assign pdl_ovf = 1'b0;
`endif
endmodule
